// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached command RAM.
//   cmd_e      : two-bit command field carried in rx_data[ADDR_SIZE+1:ADDR_SIZE]
//   rd_state_e : read-path FSM states of spi_ram_ctrl
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RD_FETCH = 2'b01,
        ST_RD_HOLD  = 2'b10
    } rd_state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Word-level link between the SPI slave and the command RAM.
//   rx_data  : {cmd[1:0], payload[ADDR_SIZE-1:0]} from the SPI slave
//   rx_valid : one-cycle strobe qualifying rx_data
//   tx_data  : read byte returned for MISO serialisation
//   tx_valid : level, high while tx_data holds a fresh read result
//   seq_err  : one-cycle pulse for a rejected command
// master = SPI slave side, slave = RAM controller side.
interface spi_ram_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 seq_err;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        input  seq_err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        output seq_err
    );
endinterface

// File: rtl/spi_ram_array.sv
// Single-port storage, DEPTH words of DATA_W bits, synchronous read, no reset.
//   clk     : clock
//   we_i    : write enable, mem[addr_i] <= wdata_i
//   re_i    : read enable, rdata_o <= mem[addr_i] (ignored when we_i is high)
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : registered read data, holds between reads
module spi_ram_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind the SPI slave. Executes WR_ADDR / WR_DATA /
// RD_ADDR / RD_DATA words and returns read bytes with a held-level valid.
//   clk : clock, all logic on posedge
//   rst : asynchronous active-high reset (memory contents survive)
//   bus : spi_ram_ctrl_if.slave (rx_data, rx_valid, tx_data, tx_valid, seq_err)
import spi_ram_pkg::*;

module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);

    localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = MEM_DEPTH;

    rd_state_e            state_q, state_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic                 wr_vld_q, wr_vld_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 seq_err_q, seq_err_d;

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 in_range;
    logic                 mem_we;
    logic                 mem_re;
    logic [AW-1:0]        mem_addr;
    logic [ADDR_SIZE-1:0] mem_rdata;

    assign cmd      = cmd_e'(bus.rx_data[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload  = bus.rx_data[ADDR_SIZE-1:0];
    assign in_range = {{(32-ADDR_SIZE){1'b0}}, payload} < DEPTH_U;

    // Write and read launch come from different commands, so they never
    // collide on the single port.
    assign mem_addr = mem_we ? wr_addr_q : rd_addr_q;

    spi_ram_array #(
        .DATA_W (ADDR_SIZE),
        .DEPTH  (MEM_DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (payload),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_vld_d   = wr_vld_q;
        rd_vld_d   = rd_vld_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        seq_err_d  = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        if (bus.rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    if (in_range) begin
                        wr_addr_d = payload[AW-1:0];
                        wr_vld_d  = 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (wr_vld_q) mem_we = 1'b1;
                    else          seq_err_d = 1'b1;
                end
                CMD_RD_ADDR: begin
                    if (in_range) begin
                        rd_addr_d = payload[AW-1:0];
                        rd_vld_d  = 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    // Only one read may be in flight; the fetch cycle rejects a new one.
                    if (rd_vld_q && (state_q != ST_RD_FETCH)) begin
                        mem_re   = 1'b1;
                        rd_vld_d = 1'b0;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                default: seq_err_d = 1'b1;
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (mem_re) state_d = ST_RD_FETCH;
            end
            ST_RD_FETCH: begin
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
                state_d    = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                // Any strobe, accepted or not, retires the held result.
                if (bus.rx_valid) begin
                    tx_valid_d = 1'b0;
                    state_d    = mem_re ? ST_RD_FETCH : ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_vld_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_vld_q   <= wr_vld_d;
            rd_vld_q   <= rd_vld_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.seq_err  = seq_err_q;

endmodule
